// File: rtl/lcd_char_responder.sv
// lcd_char_responder
// Stand-in for an HD44780-style 8-bit character LCD. Decodes bus instructions
// and data accesses, keeps a 2x16 DDRAM image, models busy time and exposes the
// display contents through a registered debug read port.
//
// Ports:
//   clk, rst           system clock, synchronous active-low reset
//   lcd_e              bus enable (asynchronous to clk)
//   lcd_rs, lcd_rw     register select (0 instr/status, 1 data), 0 write / 1 read
//   lcd_data_in        bus data from the initiator
//   lcd_data_out/_oe   read data and its drive enable
//   busy               internal busy flag
//   cursor_addr        DDRAM address counter (AC)
//   disp_on, entry_inc display-on bit and I/D bit
//   err_cnt            saturating count of accesses rejected while busy
//   rd_addr, rd_char   debug cell index (0-15 line 1, 16-31 line 2) and its byte
module lcd_char_responder #(
    parameter int unsigned CMD_CYC   = 4,
    parameter int unsigned CLEAR_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       disp_on,
    output logic       entry_inc,
    output logic [7:0] err_cnt,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char
);

    // The sweep alone needs 32 cycles, so clear can never be shorter than that.
    localparam int unsigned ClearTotal = (CLEAR_CYC < 32) ? 32 : CLEAR_CYC;
    localparam int unsigned CmdTotal   = (CMD_CYC < 1) ? 1 : CMD_CYC;
    localparam logic [15:0] ClearLast  = 16'(ClearTotal - 1);
    localparam logic [15:0] CmdLast    = 16'(CmdTotal - 1);

    localparam logic [1:0] StClearSweep = 2'd0;
    localparam logic [1:0] StIdle       = 2'd1;
    localparam logic [1:0] StExec       = 2'd2;

    // Bus synchronizers and capture registers
    logic       e_s1_q, e_s2_q, e_prev_q;
    logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
    logic [7:0] data_s1_q, data_s2_q;
    logic       rs_cap_q, rw_cap_q;
    logic [7:0] data_cap_q;
    logic [7:0] dout_q;

    // Controller state
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  ac_q, ac_d;
    logic        disp_on_q, disp_on_d;
    logic        cursor_q, cursor_d;
    logic        blink_q, blink_d;
    logic        entry_inc_q, entry_inc_d;
    logic        shift_q, shift_d;
    logic        dl_q, dl_d;
    logic        n_q, n_d;
    logic        cgram_q, cgram_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  rd_char_q;

    logic [7:0] mem_q [32];
    logic       mem_we;
    logic [4:0] mem_wa;
    logic [7:0] mem_wd;

    logic       e_fall;
    logic       status_rd;
    logic       cell_valid;
    logic [4:0] cell_idx;
    logic [7:0] cell_rd_data;

    // Configuration bits held for completeness; nothing in this model consumes them.
    logic unused_cfg;
    assign unused_cfg = ^{dl_q, n_q, cursor_q, blink_q, shift_q};

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == 7'h0F)      nxt = 7'h40;
            else if (ac == 7'h4F) nxt = 7'h00;
            else                  nxt = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      nxt = 7'h4F;
            else if (ac == 7'h40) nxt = 7'h0F;
            else                  nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

    assign busy      = (state_q != StIdle);
    assign e_fall    = e_prev_q & ~e_s2_q;
    assign status_rd = ~rs_cap_q & rw_cap_q;

    // Line 1 is AC 0x00-0x0F, line 2 is AC 0x40-0x4F; AC[6] selects the line.
    assign cell_valid   = (ac_q[5:4] == 2'b00);
    assign cell_idx     = {ac_q[6], ac_q[3:0]};
    assign cell_rd_data = (cell_valid && !cgram_q) ? mem_q[cell_idx] : 8'h20;

    assign lcd_data_out = dout_q;
    assign lcd_data_oe  = e_s2_q & e_prev_q & rw_cap_q;
    assign cursor_addr  = ac_q;
    assign disp_on      = disp_on_q;
    assign entry_inc    = entry_inc_q;
    assign err_cnt      = err_q;
    assign rd_char      = rd_char_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ac_d        = ac_q;
        disp_on_d   = disp_on_q;
        cursor_d    = cursor_q;
        blink_d     = blink_q;
        entry_inc_d = entry_inc_q;
        shift_d     = shift_q;
        dl_d        = dl_q;
        n_d         = n_q;
        cgram_d     = cgram_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_wa      = 5'd0;
        mem_wd      = 8'h00;

        case (state_q)
            StClearSweep: begin
                if (cnt_q < 16'd32) begin
                    mem_we = 1'b1;
                    mem_wa = cnt_q[4:0];
                    mem_wd = 8'h20;
                end
                if (cnt_q == ClearLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StExec: begin
                if (cnt_q == CmdLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase

        // Commit; state is StIdle whenever busy is low, so overriding state_d is safe.
        if (e_fall && !status_rd) begin
            if (busy) begin
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end else if (!rs_cap_q) begin
                state_d = StExec;
                cnt_d   = '0;
                casez (data_cap_q)
                    8'b1???????: begin
                        ac_d    = data_cap_q[6:0];
                        cgram_d = 1'b0;
                    end
                    8'b01??????: cgram_d = 1'b1;
                    8'b001?????: begin
                        dl_d = data_cap_q[4];
                        n_d  = data_cap_q[3];
                    end
                    8'b0001????: begin
                        if (!data_cap_q[3]) ac_d = ac_step(ac_q, data_cap_q[2]);
                    end
                    8'b00001???: begin
                        disp_on_d = data_cap_q[2];
                        cursor_d  = data_cap_q[1];
                        blink_d   = data_cap_q[0];
                    end
                    8'b000001??: begin
                        entry_inc_d = data_cap_q[1];
                        shift_d     = data_cap_q[0];
                    end
                    8'b0000001?: begin
                        ac_d    = 7'h00;
                        cgram_d = 1'b0;
                    end
                    8'b00000001: begin
                        state_d     = StClearSweep;
                        ac_d        = 7'h00;
                        entry_inc_d = 1'b1;
                        cgram_d     = 1'b0;
                    end
                    default: state_d = StIdle;
                endcase
            end else begin
                state_d = StExec;
                cnt_d   = '0;
                // In CGRAM mode data accesses neither touch DDRAM nor move AC.
                if (!cgram_q) begin
                    if (!rw_cap_q && cell_valid) begin
                        mem_we = 1'b1;
                        mem_wa = cell_idx;
                        mem_wd = data_cap_q;
                    end
                    ac_d = ac_step(ac_q, entry_inc_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            e_s1_q      <= 1'b0;
            e_s2_q      <= 1'b0;
            e_prev_q    <= 1'b0;
            rs_s1_q     <= 1'b0;
            rs_s2_q     <= 1'b0;
            rw_s1_q     <= 1'b0;
            rw_s2_q     <= 1'b0;
            data_s1_q   <= 8'h00;
            data_s2_q   <= 8'h00;
            rs_cap_q    <= 1'b0;
            rw_cap_q    <= 1'b0;
            data_cap_q  <= 8'h00;
            dout_q      <= 8'h00;
            state_q     <= StClearSweep;
            cnt_q       <= '0;
            ac_q        <= 7'h00;
            disp_on_q   <= 1'b0;
            cursor_q    <= 1'b0;
            blink_q     <= 1'b0;
            entry_inc_q <= 1'b1;
            shift_q     <= 1'b0;
            dl_q        <= 1'b1;
            n_q         <= 1'b1;
            cgram_q     <= 1'b0;
            err_q       <= 8'h00;
            rd_char_q   <= 8'h00;
        end else begin
            e_s1_q    <= lcd_e;
            e_s2_q    <= e_s1_q;
            e_prev_q  <= e_s2_q;
            rs_s1_q   <= lcd_rs;
            rs_s2_q   <= rs_s1_q;
            rw_s1_q   <= lcd_rw;
            rw_s2_q   <= rw_s1_q;
            data_s1_q <= lcd_data_in;
            data_s2_q <= data_s1_q;
            if (e_s2_q) begin
                rs_cap_q   <= rs_s2_q;
                rw_cap_q   <= rw_s2_q;
                data_cap_q <= data_s2_q;
            end
            if (e_s2_q && rw_s2_q) begin
                dout_q <= rs_s2_q ? cell_rd_data : {busy, ac_q};
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ac_q        <= ac_d;
            disp_on_q   <= disp_on_d;
            cursor_q    <= cursor_d;
            blink_q     <= blink_d;
            entry_inc_q <= entry_inc_d;
            shift_q     <= shift_d;
            dl_q        <= dl_d;
            n_q         <= n_d;
            cgram_q     <= cgram_d;
            err_q       <= err_d;
            rd_char_q   <= mem_q[rd_addr];
        end
    end

    // DDRAM has no reset of its own; the clear sweep started by reset fills it.
    always_ff @(posedge clk) begin
        if (rst && mem_we) mem_q[mem_wa] <= mem_wd;
    end

endmodule
